// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage state type, widths and opcode constants
package fetch_pkg;

  localparam int OPCODE_W   = 6;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Opcodes decoded by the control logic that consumes instrn_opcode
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, fetch handshake FSM and branch adder
// Optional misaligned-PC trap: FETCH_MISALIGN_CHECK_EN
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instrn,
  output logic [OPCODE_W-1:0] instrn_opcode,
  output logic                instrn_valid,
  output logic [31:0]         address_plus_4,
  output logic [31:0]         branch_address,
  input  logic [31:0]         next_address,
  input  logic                instrn_done,
  output logic [31:0]         retire_count,
  output logic                fetch_error
);

  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_VALID = ST_VALID;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [1:0] S_HALT  = ST_HALT;
`endif

  localparam logic [31:0] WORD_MASK = ~(32'(WORD_BYTES) - 32'd1);

  logic [1:0]  state;
  logic [31:0] pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_error_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      instrn       <= 32'h0;
      retire_count <= 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_error_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instrn <= imem_rdata;
            state  <= S_VALID;
          end
        end
        S_VALID: begin
          if (instrn_done) begin
            retire_count <= retire_count + 32'd1;
`ifdef FETCH_MISALIGN_CHECK_EN
            // Keep the offending address in pc so a debugger can see it
            pc <= next_address;
            if ((next_address & ~WORD_MASK) != 32'h0) begin
              state         <= S_HALT;
              fetch_error_q <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
`else
            pc    <= next_address & WORD_MASK;
            state <= S_FETCH;
`endif
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  // Request is gated by rst so nothing is issued during a reset cycle
  assign imem_req     = (state == S_FETCH) && !rst;
  assign imem_addr    = pc;
  assign instrn_valid = (state == S_VALID);

  assign instrn_opcode  = instrn[31:32-OPCODE_W];
  assign address_plus_4 = pc + 32'(WORD_BYTES);
  assign branch_address = address_plus_4 + branch_offset(instrn[15:0]);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_error = fetch_error_q;
`else
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrn;
  logic [5:0]  instrn_opcode;
  logic        instrn_valid;
  logic [31:0] address_plus_4;
  logic [31:0] branch_address;
  logic [31:0] next_address;
  logic        instrn_done;
  logic [31:0] retire_count;
  logic        fetch_error;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrn(instrn), .instrn_opcode(instrn_opcode), .instrn_valid(instrn_valid),
    .address_plus_4(address_plus_4), .branch_address(branch_address),
    .next_address(next_address), .instrn_done(instrn_done),
    .retire_count(retire_count), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: where the instruction lifecycle stands, and the architectural values
  localparam int P_NEED_REQ  = 0;
  localparam int P_IN_FLIGHT = 1;
  localparam int P_HOLDING   = 2;
  localparam int P_HALTED    = 3;

  int          m_phase = P_NEED_REQ;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_count = 32'h0;
  logic        m_err   = 1'b0;
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    int signed off;
    logic [31:0] exp_branch;
    off = $signed(m_instr[15:0]);
    exp_branch = m_pc + 32'd4 + 32'(off * 4);
    chk("imem_req", 32'(imem_req), 32'((m_phase == P_NEED_REQ) && !rst));
    if ((m_phase == P_NEED_REQ) && !rst) chk("imem_addr", imem_addr, m_pc);
    chk("instrn_valid", 32'(instrn_valid), 32'(m_phase == P_HOLDING));
    chk("instrn", instrn, m_instr);
    chk("instrn_opcode", 32'(instrn_opcode), 32'(m_instr >> 26));
    chk("address_plus_4", address_plus_4, m_pc + 32'd4);
    chk("branch_address", branch_address, exp_branch);
    chk("retire_count", retire_count, m_count);
    chk("fetch_error", 32'(fetch_error), 32'(m_err));
  endtask

  task automatic model_update();
    if (rst) begin
      m_phase = P_NEED_REQ; m_pc = 32'h0; m_instr = 32'h0; m_count = 32'h0; m_err = 1'b0;
    end else if (m_phase == P_NEED_REQ) begin
      if (imem_ready) m_phase = P_IN_FLIGHT;
    end else if (m_phase == P_IN_FLIGHT) begin
      if (imem_rvalid) begin m_instr = imem_rdata; m_phase = P_HOLDING; end
    end else if (m_phase == P_HOLDING) begin
      if (instrn_done) begin
        m_count = m_count + 32'd1;
`ifdef FETCH_MISALIGN_CHECK_EN
        m_pc = next_address;
        if (next_address % 4 != 0) begin m_phase = P_HALTED; m_err = 1'b1; end
        else m_phase = P_NEED_REQ;
`else
        m_pc = next_address - (next_address % 4);
        m_phase = P_NEED_REQ;
`endif
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_ok) compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rd,
                       input logic d, input logic [31:0] na);
    imem_ready = r; imem_rvalid = rv; imem_rdata = rd; instrn_done = d; next_address = na;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    tick();
    model_ok = 1'b1;
    tick();
    chk("reset_instrn_valid", 32'(instrn_valid), 32'h0);
    chk("reset_branch", branch_address, 32'h4);

    // First fetch: accept, response one cycle later, valid at cycle 2
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h8C22_0004, 1'b0, 32'h0);
    tick();
    chk("lw_valid", 32'(instrn_valid), 32'h1);
    chk("lw_opcode", 32'(instrn_opcode), 32'h23);
    chk("lw_plus4", address_plus_4, 32'h4);
    chk("lw_branch", branch_address, 32'h14);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    tick();
    chk("retire_req", 32'(imem_req), 32'h1);
    chk("retire_addr", imem_addr, 32'h40);
    chk("retire_count", retire_count, 32'h1);

    // Reach PC 0x100 and fetch a BEQ with offset -1
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);  tick();
    drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0);  tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h100); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);  tick();
    drive(1'b1, 1'b1, 32'h1000_FFFF, 1'b0, 32'h0); tick();
    chk("beq_branch", branch_address, 32'h100);
    chk("beq_opcode", 32'(instrn_opcode), 32'h04);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200); tick();

    // Stalled accept, delayed response, stray instrn_done while not VALID
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h999);
      tick();
      chk("stall_addr", imem_addr, 32'h200);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h999); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h999);
      tick();
      chk("wait_not_valid", 32'(instrn_valid), 32'h0);
    end
    drive(1'b0, 1'b1, 32'hAC01_0008, 1'b0, 32'h0); tick();
    chk("late_valid", 32'(instrn_valid), 32'h1);
    chk("stray_done_count", retire_count, 32'h3);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h300); tick();

    // Reset during WAIT, stale response right after
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0); tick();
    chk("stale_pc", imem_addr, 32'h0);
    chk("stale_instrn", instrn, 32'h0);
    chk("stale_valid", 32'(instrn_valid), 32'h0);
    chk("stale_count", retire_count, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] na;
      rst = ($urandom_range(0, 199) == 0);
      na = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      na[1:0] = 2'b00;
`else
      if ($urandom_range(0, 3) != 0) na[1:0] = 2'b00;
`endif
      drive($urandom_range(0, 1) == 1,
            (m_phase == P_IN_FLIGHT) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 2),
            $urandom, $urandom_range(0, 9) < 4, na);
      tick();
    end

    // PC wrap at the top of the address space
    rst = 1'b1; drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 32'h0000_FFFF, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC); tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_plus4", address_plus_4, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0); tick();
    chk("wrap_branch", branch_address, 32'h4);

    // Misaligned next_address
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h42); tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h0, 1'b1, 32'h0);
      tick();
      chk("halt_error", 32'(fetch_error), 32'h1);
      chk("halt_req", 32'(imem_req), 32'h0);
      chk("halt_valid", 32'(instrn_valid), 32'h0);
    end
`else
    chk("misalign_addr", imem_addr, 32'h40);
    chk("misalign_error", 32'(fetch_error), 32'h0);
    chk("misalign_req", 32'(imem_req), 32'h1);
`endif
    chk("misalign_count", retire_count, 32'h2);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the control logic. It holds the program counter and issues word fetches to instruction memory over a request/response handshake. It presents the fetched instruction, its opcode, PC+4 and the branch target to the downstream stage. When that stage retires the instruction, the fetch stage loads the next address it selected.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address (current PC)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  fetched instruction word
- instrn  out  32  latched instruction
- instrn_opcode  out  6  instrn[31:26]
- instrn_valid  out  1  instrn and derived outputs are valid
- address_plus_4  out  32  PC + 4
- branch_address  out  32  PC + 4 + (sign-extended instrn[15:0] << 2)
- next_address  in  32  next PC chosen downstream
- instrn_done  in  1  downstream retires the current instruction; next_address is valid
- retire_count  out  32  instructions retired since reset
- fetch_error  out  1  misaligned next_address trapped (see Configuration)

## Operation
- States: FETCH, WAIT, VALID, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - imem_req && imem_ready -> WAIT.
  - imem_rvalid is ignored in FETCH.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: instrn<=imem_rdata, then -> VALID.
- VALID:
  - instrn_valid=1.
  - On instrn_done: pc<=next_address, retire_count+=1, then -> FETCH.
- HALT:
  - Exists only with FETCH_MISALIGN_CHECK_EN.
  - Terminal until rst.
  - imem_req=0, instrn_valid=0, fetch_error=1.
- instrn_done outside VALID is ignored.
- Derived outputs are combinational from registered pc/instrn:
  - instrn_opcode = instrn[31:26].
  - address_plus_4 = pc+4.
  - branch_address = pc+4 + {{14{instrn[15]}},instrn[15:0],2'b00}.
- All arithmetic is 32-bit modulo; PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
- retire_count wraps at 2^32 silently.
- Memory contract: one outstanding request, responses in order, memory reset by the same rst.

## Timing
- Reset values:
  - state=FETCH, pc=RESET_PC, instrn=0, instrn_valid=0, retire_count=0, fetch_error=0.
  - imem_req=0 during the rst cycle; imem_req=1 from the first cycle after rst deasserts.
  - address_plus_4=RESET_PC+4 and branch_address=RESET_PC+4.
- Minimum fetch latency is 2 cycles:
  - cycle 0: accept.
  - cycle 1: earliest imem_rvalid.
  - cycle 2: instrn_valid=1.
- imem_ready=0 holds the request with imem_addr stable.
- VALID with instrn_done=1 goes to FETCH the next cycle with the new PC on imem_addr. Minimum issue interval is 3 cycles per instruction.
- instrn and its derived outputs stay stable from VALID until the cycle after instrn_done.
- rst has priority over every transition, including mid-WAIT. The abandoned response never reaches instrn.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - On instrn_done, if next_address[1:0]!=0: enter HALT; pc<=next_address for debug; retire_count still increments.
  - fetch_error is a registered output, high from the next cycle.
- Undefined:
  - pc<=next_address & ~32'h3.
  - fetch_error is tied 0; HALT state does not exist.

## Structure
- Shared package fetch_pkg:
  - state enum (FETCH, WAIT, VALID, HALT).
  - OPCODE_W=6, WORD_BYTES=4.
  - Opcode constants shared with control logic: R-type 6'h00, BEQ 6'h04, LW 6'h23, SW 6'h2B.
- No sub-module; the PC register, FSM and branch adder are one flat module.

## Test plan
- Reset release, imem_ready=1, rvalid one cycle after accept, rdata=32'h8C220004 -> imem_addr=0; instrn_valid at cycle 2; instrn_opcode=6'h23; address_plus_4=4; branch_address=32'h14.
- instrn_done with next_address=32'h40 -> next cycle imem_req=1, imem_addr=32'h40, retire_count=1.
- BEQ 32'h1000FFFF fetched at PC=32'h100 -> branch_address=32'h100.
- imem_ready low 3 cycles, then rvalid delayed 4 cycles -> imem_addr held stable; a single instrn_valid rise; instrn_done while not VALID has no effect.
- rst asserted during WAIT, stale rvalid arrives the next cycle -> pc=RESET_PC, instrn=0, instrn_valid=0.
- next_address=32'h42: with FETCH_MISALIGN_CHECK_EN -> HALT, fetch_error=1, imem_req=0. Without it -> imem_addr=32'h40.
